// File: rtl/mp_seq_ctrl_if.sv
// Handshake and status bundle between the sequencer and its arithmetic-unit host.
// The slave side belongs to mp_seq_ctrl; the master side drives requests and watches status.
interface mp_seq_ctrl_if;
  logic       op_start;
  logic       op_done;
  logic       interrupt;
  logic       abort;
  logic [3:0] state;
  logic       op_rd;
  logic       opnd_rd;
  logic [1:0] opnd_idx;
  logic       cal_en;
  logic       result_valid;
  logic       busy;
  logic       error;
  logic [7:0] op_count;

  modport slave (
    input  op_start, op_done, interrupt, abort,
    output state, op_rd, opnd_rd, opnd_idx, cal_en, result_valid, busy, error, op_count
  );

  modport master (
    output op_start, op_done, interrupt, abort,
    input  state, op_rd, opnd_rd, opnd_idx, cal_en, result_valid, busy, error, op_count
  );
endinterface

// File: rtl/mp_seq_ctrl.sv
// Multi-phase operation sequencer: opcode read, operand reads, arithmetic with timeout,
// then select/loop; all outputs are Moore decodes of the state register and counters.
module mp_seq_ctrl #(
  parameter int N_OPND   = 2,
  parameter int WAIT_CYC = 1,
  parameter int TIMEOUT  = 255,
  parameter int MAX_OPS  = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  mp_seq_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_OP_READ   = 4'd1,
    S_OP_WAIT1  = 4'd2,
    S_OPND_READ = 4'd3,
    S_OP_WAIT2  = 4'd5,
    S_OP_CAL    = 4'd6,
    S_SELECT    = 4'd7,
    S_RESULT    = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC - 1);
  localparam logic [1:0] OPND_LAST = 2'(N_OPND - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_stateNext;
  logic [2:0] r_waitCnt;
  logic [1:0] r_opndIdx;
  logic [7:0] r_toCnt;
  logic [7:0] r_opCount;
  logic [7:0] w_opCountInc;
  logic       w_stopRun;

  assign w_opCountInc = (r_opCount == 8'hFF) ? r_opCount : r_opCount + 8'd1;
  assign w_stopRun    = bus.interrupt || ((MAX_OPS != 0) && (int'(w_opCountInc) >= MAX_OPS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_stateNext;
  end

  // abort overrides every state; op_done is only looked at in OP_CAL and wins over timeout
  always_comb begin
    w_stateNext = r_state;
    if (bus.abort) begin
      w_stateNext = S_INIT;
    end else begin
      case (r_state)
        S_INIT:      if (bus.op_start) w_stateNext = S_OP_READ;
        S_OP_READ:   w_stateNext = (WAIT_CYC == 0) ? S_OPND_READ : S_OP_WAIT1;
        S_OP_WAIT1:  if (r_waitCnt == WAIT_LAST) w_stateNext = S_OPND_READ;
        S_OPND_READ: if (r_opndIdx == OPND_LAST)
                       w_stateNext = (WAIT_CYC == 0) ? S_OP_CAL : S_OP_WAIT2;
        S_OP_WAIT2:  if (r_waitCnt == WAIT_LAST) w_stateNext = S_OP_CAL;
        S_OP_CAL: begin
          if (bus.op_done)             w_stateNext = S_SELECT;
          else if (r_toCnt == TO_LAST) w_stateNext = S_ERROR;
        end
        S_SELECT:    w_stateNext = w_stopRun ? S_RESULT : S_OP_READ;
        S_RESULT:    w_stateNext = S_RESULT;
        S_ERROR:     w_stateNext = S_ERROR;
        default:     w_stateNext = S_INIT;
      endcase
    end
  end

  // Phase counters run only while their phase persists, so each clears on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_waitCnt <= 3'd0;
      r_opndIdx <= 2'd0;
      r_toCnt   <= 8'd0;
      r_opCount <= 8'd0;
    end else if (bus.abort) begin
      r_waitCnt <= 3'd0;
      r_opndIdx <= 2'd0;
      r_toCnt   <= 8'd0;
      r_opCount <= 8'd0;
    end else begin
      r_waitCnt <= ((r_state == S_OP_WAIT1 || r_state == S_OP_WAIT2) && w_stateNext == r_state)
                   ? r_waitCnt + 3'd1 : 3'd0;
      r_opndIdx <= (r_state == S_OPND_READ && w_stateNext == S_OPND_READ) ? r_opndIdx + 2'd1 : 2'd0;
      r_toCnt   <= (r_state == S_OP_CAL && w_stateNext == S_OP_CAL) ? r_toCnt + 8'd1 : 8'd0;
      if (r_state == S_SELECT) r_opCount <= w_opCountInc;
    end
  end

  assign bus.state        = r_state;
  assign bus.op_rd        = (r_state == S_OP_READ);
  assign bus.opnd_rd      = (r_state == S_OPND_READ);
  assign bus.opnd_idx     = (r_state == S_OPND_READ) ? r_opndIdx : 2'd0;
  assign bus.cal_en       = (r_state == S_OP_CAL);
  assign bus.result_valid = (r_state == S_RESULT);
  assign bus.error        = (r_state == S_ERROR);
  assign bus.busy         = !(r_state == S_INIT || r_state == S_RESULT || r_state == S_ERROR);
  assign bus.op_count     = r_opCount;

endmodule

// File: tb/tb_mp_seq_ctrl.sv
// Bench for mp_seq_ctrl: two configurations checked every cycle against a phase/cycle-count
// model, plus directed sequences with literal expectations and a randomized soak.
module tb_mp_seq_ctrl;
  localparam int A_N = 2, A_W = 1, A_T = 255, A_M = 0;
  localparam int B_N = 3, B_W = 0, B_T = 4,   B_M = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  mp_seq_ctrl_if ifA ();
  mp_seq_ctrl_if ifB ();

  mp_seq_ctrl #(.N_OPND(A_N), .WAIT_CYC(A_W), .TIMEOUT(A_T), .MAX_OPS(A_M)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(ifA)
  );
  mp_seq_ctrl #(.N_OPND(B_N), .WAIT_CYC(B_W), .TIMEOUT(B_T), .MAX_OPS(B_M)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(ifB)
  );

  always #5 clk = ~clk;

  typedef struct { int phase; int cyc; int ops; } mdl_t;
  typedef struct {
    int state; int opRd; int opndRd; int opndIdx; int calEn;
    int resV; int busy; int err; int opCnt;
  } obs_t;

  mdl_t mA = '{0, 0, 0};
  mdl_t mB = '{0, 0, 0};

  // phase = spec state number, cyc = cycles already spent in that phase, ops = completed ops
  function automatic mdl_t mdlStep(mdl_t m, int nOp, int w, int to, int mx,
                                   logic start, logic done, logic intr, logic abt);
    mdl_t r;
    r = m;
    if (abt) begin
      r.phase = 0;
      r.ops   = 0;
    end else begin
      case (m.phase)
        0: if (start) r.phase = 1;
        1: r.phase = (w == 0) ? 3 : 2;
        2: if (m.cyc + 1 >= w) r.phase = 3;
        3: if (m.cyc + 1 >= nOp) r.phase = (w == 0) ? 6 : 5;
        5: if (m.cyc + 1 >= w) r.phase = 6;
        6: begin
          if (done) r.phase = 7;
          else if (m.cyc + 1 >= to) r.phase = 9;
        end
        7: begin
          r.ops   = (m.ops < 255) ? m.ops + 1 : 255;
          r.phase = (intr || (mx != 0 && r.ops >= mx)) ? 8 : 1;
        end
        default: ;
      endcase
    end
    if (r.phase == m.phase && !abt) r.cyc = (m.cyc < 1000) ? m.cyc + 1 : m.cyc;
    else r.cyc = 0;
    return r;
  endfunction

  function automatic obs_t expOf(mdl_t m);
    obs_t e;
    e.state   = m.phase;
    e.opRd    = (m.phase == 1) ? 1 : 0;
    e.opndRd  = (m.phase == 3) ? 1 : 0;
    e.opndIdx = (m.phase == 3) ? m.cyc : 0;
    e.calEn   = (m.phase == 6) ? 1 : 0;
    e.resV    = (m.phase == 8) ? 1 : 0;
    e.err     = (m.phase == 9) ? 1 : 0;
    e.busy    = (m.phase == 0 || m.phase == 8 || m.phase == 9) ? 0 : 1;
    e.opCnt   = m.ops;
    return e;
  endfunction

  function automatic obs_t obsOf(int sel);
    obs_t o;
    if (sel == 0) begin
      o = '{int'(ifA.state), int'(ifA.op_rd), int'(ifA.opnd_rd), int'(ifA.opnd_idx), int'(ifA.cal_en),
            int'(ifA.result_valid), int'(ifA.busy), int'(ifA.error), int'(ifA.op_count)};
    end else begin
      o = '{int'(ifB.state), int'(ifB.op_rd), int'(ifB.opnd_rd), int'(ifB.opnd_idx), int'(ifB.cal_en),
            int'(ifB.result_valid), int'(ifB.busy), int'(ifB.error), int'(ifB.op_count)};
    end
    return o;
  endfunction

  task automatic checkVal(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag, obs_t act, obs_t exp);
    checkVal({tag, ".state"},        act.state,   exp.state);
    checkVal({tag, ".op_rd"},        act.opRd,    exp.opRd);
    checkVal({tag, ".opnd_rd"},      act.opndRd,  exp.opndRd);
    checkVal({tag, ".opnd_idx"},     act.opndIdx, exp.opndIdx);
    checkVal({tag, ".cal_en"},       act.calEn,   exp.calEn);
    checkVal({tag, ".result_valid"}, act.resV,    exp.resV);
    checkVal({tag, ".busy"},         act.busy,    exp.busy);
    checkVal({tag, ".error"},        act.err,     exp.err);
    checkVal({tag, ".op_count"},     act.opCnt,   exp.opCnt);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mA <= '{0, 0, 0};
      mB <= '{0, 0, 0};
    end else begin
      mA <= mdlStep(mA, A_N, A_W, A_T, A_M, ifA.op_start, ifA.op_done, ifA.interrupt, ifA.abort);
      mB <= mdlStep(mB, B_N, B_W, B_T, B_M, ifB.op_start, ifB.op_done, ifB.interrupt, ifB.abort);
    end
  end

  always @(negedge clk) begin
    checkOutput("modelA", obsOf(0), expOf(mA));
    checkOutput("modelB", obsOf(1), expOf(mB));
  end

  task automatic applyStimulus(int sel, logic start, logic done, logic intr, logic abt);
    if (sel == 0) begin
      ifA.op_start = start; ifA.op_done = done; ifA.interrupt = intr; ifA.abort = abt;
    end else begin
      ifB.op_start = start; ifB.op_done = done; ifB.interrupt = intr; ifB.abort = abt;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitState(int sel, int target, int budget);
    for (int i = 0; i < budget; i++) begin
      if (obsOf(sel).state == target) break;
      tick();
    end
    checkVal("waitState", obsOf(sel).state, target);
  endtask

  obs_t zeroObs = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int   seqA[10] = '{1, 2, 3, 3, 5, 6, 6, 6, 7, 1};
  int   seqB[18] = '{1, 3, 3, 3, 6, 6, 6, 6, 7, 1, 3, 3, 3, 6, 6, 6, 6, 9};

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    #1;
    checkOutput("rstA", obsOf(0), zeroObs);
    checkOutput("rstB", obsOf(1), zeroObs);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkVal("idleA.state", obsOf(0).state, 0);

    // default config: full pass with op_done on the third OP_CAL cycle
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkVal("seqA.state", obsOf(0).state, seqA[k]);
      if (k == 2) checkVal("seqA.idx0", obsOf(0).opndIdx, 0);
      if (k == 3) checkVal("seqA.idx1", obsOf(0).opndIdx, 1);
      applyStimulus(0, 0, (k == 7) ? 1'b1 : 1'b0, 0, 0);
    end
    checkVal("seqA.op_count", obsOf(0).opCnt, 1);

    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkVal("abortA.state", obsOf(0).state, 0);
    checkVal("abortA.op_count", obsOf(0).opCnt, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    waitState(0, 6, 20);
    applyStimulus(0, 0, 1, 1, 0);
    tick();
    checkVal("intrA.select", obsOf(0).state, 7);
    applyStimulus(0, 0, 0, 1, 0);
    tick();
    checkVal("intrA.state", obsOf(0).state, 8);
    checkVal("intrA.result_valid", obsOf(0).resV, 1);
    checkVal("intrA.op_count", obsOf(0).opCnt, 1);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);

    // WAIT_CYC=0 / N_OPND=3 / TIMEOUT=4: exact-timeout done, then a real timeout
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      tick();
      checkVal("seqB.state", obsOf(1).state, seqB[k]);
      if (k >= 1 && k <= 3) checkVal("seqB.idx", obsOf(1).opndIdx, k - 1);
      applyStimulus(1, 0, (k == 7) ? 1'b1 : 1'b0, 0, 0);
    end
    checkVal("errB.error", obsOf(1).err, 1);
    checkVal("errB.busy", obsOf(1).busy, 0);
    checkVal("errB.op_count", obsOf(1).opCnt, 1);
    applyStimulus(1, 1, 0, 0, 0);
    tick();
    checkVal("errB.ignoreStart", obsOf(1).state, 9);
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    checkVal("errB.abortState", obsOf(1).state, 0);
    checkVal("errB.abortCount", obsOf(1).opCnt, 0);

    applyStimulus(1, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    for (int op = 0; op < 3; op++) begin
      waitState(1, 6, 20);
      applyStimulus(1, 0, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0, 0);
      checkVal("maxB.select", obsOf(1).state, 7);
      tick();
      checkVal("maxB.after", obsOf(1).state, (op < 2) ? 1 : 8);
    end
    checkVal("maxB.op_count", obsOf(1).opCnt, 3);
    checkVal("maxB.result_valid", obsOf(1).resV, 1);
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0);

    // asynchronous reset in the middle of OPND_READ
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    waitState(0, 3, 20);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncRstA", obsOf(0), zeroObs);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkVal("postRst.state", obsOf(0).state, 0);
    applyStimulus(0, 1, 0, 0, 1);
    tick();
    checkVal("abortStart.state", obsOf(0).state, 0);
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkVal("abortStart.hold", obsOf(0).state, 0);

    for (int c = 0; c < 4000; c++) begin
      tick();
      applyStimulus(0, ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                    ($urandom_range(7) == 0), ($urandom_range(49) == 0));
      applyStimulus(1, ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                    ($urandom_range(7) == 0), ($urandom_range(39) == 0));
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
